stepper_move_controller: RTL
============================

# stepper_move_controller

Move sequencer that sits in front of `track_step_driver`. It accepts one move command at a time: a direction plus a step count. It produces the `en`/`direction` inputs for the driver as a train of single-cycle step-enable pulses, with a trapezoidal velocity profile built from a programmable clock divider. It also keeps a signed absolute position count for the kitchen-helper track axis.

## Interface
- `STEP_W`, 16: width of the step-count field.
- `DIV_W`, 24: width of the period counter, in clk cycles.
- `POS_W`, 24: width of the signed position counter.
- `START_DIV`, 500000: initial and final step period in cycles. Must be ≥ 2.
- `MIN_DIV`, 100000: cruise (shortest) step period. 2 ≤ MIN_DIV ≤ START_DIV.
- `RAMP_DEC`, 1000: period change applied per step while ramping.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: a move command is presented.
- `cmd_ready` out 1: controller idle; the command is accepted on `cmd_valid && cmd_ready`.
- `cmd_dir` in 1: 1 = positive (driver direction 1), 0 = negative.
- `cmd_steps` in STEP_W: number of steps to execute.
- `abort` in 1: stop the current move.
- `pos_zero` in 1: clear the position counter. Honoured only while idle.
- `step_en` out 1: one-cycle pulse; connects to driver `en`.
- `motor_dir` out 1: connects to driver `direction`. Holds the direction of the last accepted command.
- `busy` out 1: a move is in progress.
- `done` out 1: one-cycle pulse when a move finishes or is aborted.
- `aborted` out 1: valid with `done`; 1 if the move ended by `abort`.
- `position` out POS_W: signed absolute step count.

## Operation
- States: IDLE and RUN.
- IDLE: `cmd_ready`=1, `busy`=0.
- On acceptance:
  - latch `motor_dir`=`cmd_dir` and `remaining`=`cmd_steps`;
  - set `cur_div`=START_DIV, `div_cnt`=START_DIV, `ramp_cnt`=0;
  - go to RUN.
- `cmd_steps`=0: command is still accepted. The controller does not enter RUN. `done`=1 and `aborted`=0 in the next cycle, with no step pulse.
- RUN: `div_cnt` decrements every cycle. In the cycle where `div_cnt`==1:
  - `step_en`=1;
  - `remaining` decrements, giving rem' = new value;
  - `position` is incremented by 1 (dir=1) or decremented by 1 (dir=0), two's-complement wrap;
  - the next period is chosen from `cur_div`, then `div_cnt` is reloaded with it.
- Next-period rule (exactly one branch applies, checked in this order):
  - Decel: rem' ≤ `ramp_cnt` and `ramp_cnt`>0 → `cur_div` = min(`cur_div`+RAMP_DEC, START_DIV), `ramp_cnt` −1.
  - Accel: else if `cur_div` > MIN_DIV → `cur_div` = max(`cur_div`−RAMP_DEC, MIN_DIV), `ramp_cnt` +1.
  - Cruise: otherwise `cur_div` is unchanged.
- Move completion: rem'==0 → next cycle returns to IDLE with `done`=1, `aborted`=0.
- Abort: `abort` high in RUN → next cycle IDLE, `done`=1, `aborted`=1, no further pulses.
  - If `abort` coincides with a `step_en` cycle, that step still counts in `position`.
- `abort` in IDLE has no effect.
- `cmd_valid` while busy is ignored; it is not queued.
- `pos_zero` in IDLE: `position`=0 next cycle. If it coincides with command acceptance, both take effect.
- `pos_zero` in RUN is ignored.
- Reset, at any time including mid-move: state=IDLE, `step_en`=0, `motor_dir`=0, `busy`=0, `done`=0, `aborted`=0, `position`=0, `cmd_ready`=1.
  - Internal counters are cleared.
  - The driver sees `en`=0 and de-energises to its stop state.

## Timing
- Acceptance edge = cycle 0. The first `step_en` is high during cycle START_DIV.
- Spacing between consecutive `step_en` pulses equals the `cur_div` value selected at the earlier pulse.
- The last `step_en` is at cycle T. Then `done` is high in cycle T+1, and `cmd_ready`=1 from cycle T+1.
- A new command may be accepted in cycle T+1.
- `step_en` is never high for two consecutive cycles.
- `busy` = (state==RUN) and is registered.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: START_DIV=10, MIN_DIV=4, RAMP_DEC=2.
- Reset then idle → `cmd_ready`=1, `position`=0, `step_en` never pulses over 100 cycles.
- Move of 6 steps, dir=1, accepted at cycle 0:
  - `step_en` at cycles 10, 18, 24, 28, 34, 42;
  - `done` at cycle 43 with `aborted`=0;
  - `position`=6.
- Then 6 steps, dir=0 → the same pulse spacing and `motor_dir`=0; `position` returns to 0.
- `cmd_steps`=0 → `done` at cycle 1, no `step_en`, `position` unchanged.
- 6-step move with `abort` asserted in cycle 20 → pulses at 10 and 18 only, `done`+`aborted` at cycle 21, `position`=2.
- `cmd_valid` pulsed mid-move → ignored. `pos_zero` mid-move → ignored; in IDLE → `position`=0. `rst_n` low at cycle 15 of a move → all outputs at reset values immediately, no further pulses.

Source files
------------

// File: rtl/stepper_move_controller.sv
// Move sequencer for track_step_driver: takes one (direction, step count) command at a time and
// emits single-cycle step pulses with a trapezoidal period profile while tracking signed position.
module stepper_move_controller #(
  parameter int STEP_W    = 16,
  parameter int DIV_W     = 24,
  parameter int POS_W     = 24,
  parameter int START_DIV = 500000,
  parameter int MIN_DIV   = 100000,
  parameter int RAMP_DEC  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  input  logic              pos_zero,
  output logic              step_en,
  output logic              motor_dir,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [POS_W-1:0]  position
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [DIV_W-1:0] LP_START_D = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] LP_MIN_D   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] LP_DEC_D   = DIV_W'(RAMP_DEC);
  localparam logic [DIV_W-1:0] LP_ONE_D   = DIV_W'(1);
  localparam logic [DIV_W:0]   LP_START_W = (DIV_W+1)'(START_DIV);
  localparam logic [DIV_W:0]   LP_MIN_W   = (DIV_W+1)'(MIN_DIV);
  localparam logic [DIV_W:0]   LP_DEC_W   = (DIV_W+1)'(RAMP_DEC);

  state_t              r_state, w_state;
  logic [STEP_W-1:0]   r_rem, w_rem, r_ramp, w_ramp, w_rem_dec;
  logic [DIV_W-1:0]    r_cur_div, w_cur_div, r_div_cnt, w_div_cnt;
  logic [DIV_W:0]      w_up;
  logic                r_zpend, w_zpend;
  logic                r_step_en, w_step_en;
  logic                r_dir, w_dir;
  logic                r_done, w_done;
  logic                r_aborted, w_aborted;
  logic [POS_W-1:0]    r_pos, w_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_ramp    <= '0;
      r_cur_div <= '0;
      r_div_cnt <= '0;
      r_zpend   <= 1'b0;
      r_step_en <= 1'b0;
      r_dir     <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_state   <= w_state;
      r_rem     <= w_rem;
      r_ramp    <= w_ramp;
      r_cur_div <= w_cur_div;
      r_div_cnt <= w_div_cnt;
      r_zpend   <= w_zpend;
      r_step_en <= w_step_en;
      r_dir     <= w_dir;
      r_done    <= w_done;
      r_aborted <= w_aborted;
      r_pos     <= w_pos;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_rem     = r_rem;
    w_ramp    = r_ramp;
    w_cur_div = r_cur_div;
    w_div_cnt = r_div_cnt;
    w_zpend   = 1'b0;
    w_step_en = 1'b0;
    w_dir     = r_dir;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    w_pos     = r_pos;
    w_rem_dec = r_rem - 1'b1;
    w_up      = {1'b0, r_cur_div} + LP_DEC_W;
    case (r_state)
      S_IDLE: begin
        // zero-step commands never enter RUN; the pending flag delays done by one cycle
        w_done = r_zpend;
        if (pos_zero) w_pos = '0;
        if (cmd_valid) begin
          w_dir     = cmd_dir;
          w_rem     = cmd_steps;
          w_cur_div = LP_START_D;
          w_div_cnt = LP_START_D;
          w_ramp    = '0;
          if (cmd_steps == '0) w_zpend = 1'b1;
          else                 w_state = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state   = S_IDLE;
          w_done    = 1'b1;
          w_aborted = 1'b1;
        end else if (r_rem == '0) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else if (r_div_cnt == LP_ONE_D) begin
          w_step_en = 1'b1;
          w_rem     = w_rem_dec;
          w_pos     = r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
          if ((w_rem_dec <= r_ramp) && (r_ramp != '0)) begin
            w_cur_div = (w_up > LP_START_W) ? LP_START_D : w_up[DIV_W-1:0];
            w_ramp    = r_ramp - 1'b1;
          end else if (r_cur_div > LP_MIN_D) begin
            w_cur_div = ({1'b0, r_cur_div} > (LP_MIN_W + LP_DEC_W)) ? (r_cur_div - LP_DEC_D) : LP_MIN_D;
            w_ramp    = r_ramp + 1'b1;
          end
          w_div_cnt = w_cur_div;
        end else begin
          w_div_cnt = r_div_cnt - 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign step_en   = r_step_en;
  assign motor_dir = r_dir;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign position  = r_pos;

endmodule
